// File: rtl/ee354_project_pkg.sv
// Direction codes shared by the button encoder, the direction queue and the length logic.
package ee354_project_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dirn_e;

    // Codes differ only in bit 0 exactly when they point along the same axis in opposite senses.
    function automatic logic dirn_is_opposite(input logic [1:0] a, input logic [1:0] b);
        return ((a ^ b) == 2'b01);
    endfunction

endpackage

// File: rtl/ee354_project_dirn_queue_if.sv
// Direction-command bus between the top-level encoder and the direction queue.
interface ee354_project_dirn_queue_if #(
    parameter int DEPTH = 4
) ();
    localparam int CW = $clog2(DEPTH) + 1;

    logic          SCEN;
    logic [1:0]    In_Dirn;
    logic          Step;
    logic [1:0]    Cur_Dirn;
    logic [CW-1:0] Queue_Count;
    logic          Drop;

    modport master (
        output SCEN, In_Dirn,
        input  Step, Cur_Dirn, Queue_Count, Drop
    );

    modport slave (
        input  SCEN, In_Dirn,
        output Step, Cur_Dirn, Queue_Count, Drop
    );
endinterface

// File: rtl/ee354_project_dirn_fifo.sv
// Generic 2-bit-wide synchronous FIFO with separate count; push and pop together are legal when full.
module ee354_project_dirn_fifo #(
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          sys_clk,
    input  logic          Reset,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [1:0]    wdata,
    output logic [1:0]    head,
    output logic [1:0]    tail,
    output logic [CW-1:0] count
);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [1:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_r;
    logic          do_pop;
    logic          do_push;

    assign do_pop  = pop && (count_r != '0);
    assign do_push = push && ((count_r != FULL) || do_pop);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sys_clk) begin
        if (Reset || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_r <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count_r <= count_r + 1'b1;
            else if (do_pop && !do_push) count_r <= count_r - 1'b1;
        end
    end

    // NOTE: storage has no reset; the count alone decides which entries are meaningful.
    always_ff @(posedge sys_clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign head  = mem[rd_ptr];
    assign tail  = mem[wr_ptr - 1'b1];
    assign count = count_r;

endmodule

// File: rtl/ee354_project_dirn_queue.sv
// Filters and buffers direction commands and applies at most one per Speed_Clk game tick.
module ee354_project_dirn_queue
    import ee354_project_pkg::*;
#(
    parameter int         DEPTH     = 4,
    parameter logic [1:0] INIT_DIRN = 2'b11,
    localparam int        CW        = $clog2(DEPTH) + 1
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         Speed_Clk,
    input  logic                         q_I,
    input  logic                         q_Run,
    ee354_project_dirn_queue_if.slave    bus
);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic          s1, s2, s3;
    logic          tick;
    logic          step_r;
    logic          drop_r;
    logic [1:0]    cur_dirn;
    logic [1:0]    head;
    logic [1:0]    tail;
    logic [CW-1:0] count;
    logic [1:0]    ref_dirn;
    logic          offer;
    logic          reject;
    logic          pop;
    logic          push;

    // Speed_Clk is asynchronous: two flops synchronise it, the third gives the rising-edge reference.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= Speed_Clk;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign tick = s2 & ~s3;

    // New commands are compared against the last direction that will be in effect before them.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        ref_dirn = cur_dirn;
        if (count != '0) ref_dirn = tail;
    end

    assign offer  = bus.SCEN && q_Run && !q_I;
    assign pop    = tick && q_Run && !q_I && (count != '0);
    assign reject = dirn_is_opposite(bus.In_Dirn, ref_dirn)
                 || (bus.In_Dirn == ref_dirn)
                 || ((count == FULL) && !pop);
    assign push   = offer && !reject;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cur_dirn <= INIT_DIRN;
            step_r   <= 1'b0;
            drop_r   <= 1'b0;
        end else begin
            step_r <= tick && q_Run;
            drop_r <= offer && reject;
            if (q_I)      cur_dirn <= INIT_DIRN;
            else if (pop) cur_dirn <= head;
        end
    end

    ee354_project_dirn_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .sys_clk (Clk),
        .Reset   (Reset),
        .flush   (q_I),
        .push    (push),
        .pop     (pop),
        .wdata   (bus.In_Dirn),
        .head    (head),
        .tail    (tail),
        .count   (count)
    );

    assign bus.Step        = step_r;
    assign bus.Cur_Dirn    = cur_dirn;
    assign bus.Queue_Count = count;
    assign bus.Drop        = drop_r;

endmodule

// File: tb/tb_ee354_project_dirn_queue.sv
// Directed vectors for the direction queue: filtering, tick timing, full/flush/freeze and reset.
module tb_ee354_project_dirn_queue;
    import ee354_project_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic Clk = 1'b0;
    logic Reset;
    logic Speed_Clk;
    logic q_I;
    logic q_Run;

    ee354_project_dirn_queue_if #(.DEPTH(DEPTH)) bus ();

    ee354_project_dirn_queue #(
        .DEPTH     (DEPTH),
        .INIT_DIRN (2'b11)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Speed_Clk (Speed_Clk),
        .q_I       (q_I),
        .q_Run     (q_Run),
        .bus       (bus.slave)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic          rst;
        logic          scen;
        logic [1:0]    dirn;
        logic          spd;
        logic          qi;
        logic          qrun;
        logic          e_step;
        logic [1:0]    e_dirn;
        logic [CW-1:0] e_cnt;
        logic          e_drop;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic v(input logic rst, input logic scen, input logic [1:0] dirn, input logic spd,
                     input logic qi, input logic qrun, input logic e_step, input logic [1:0] e_dirn,
                     input logic [CW-1:0] e_cnt, input logic e_drop);
        vec_t t;
        t.rst = rst; t.scen = scen; t.dirn = dirn; t.spd = spd; t.qi = qi; t.qrun = qrun;
        t.e_step = e_step; t.e_dirn = e_dirn; t.e_cnt = e_cnt; t.e_drop = e_drop;
        vecs.push_back(t);
    endtask

    task automatic tick_clk();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_outputs(input string tag, input logic e_step, input logic [1:0] e_dirn,
                                 input logic [CW-1:0] e_cnt, input logic e_drop);
        check({tag, " Step"},        8'(bus.Step),        8'(e_step));
        check({tag, " Cur_Dirn"},    8'(bus.Cur_Dirn),    8'(e_dirn));
        check({tag, " Queue_Count"}, 8'(bus.Queue_Count), 8'(e_cnt));
        check({tag, " Drop"},        8'(bus.Drop),        8'(e_drop));
    endtask

    localparam logic [1:0] U = DIR_UP, D = DIR_DOWN, L = DIR_LEFT, R = DIR_RIGHT;

    initial begin
        int edges;

        // Reset with Speed_Clk already high: no spurious tick afterwards.
        Reset = 1'b1; Speed_Clk = 1'b1; q_I = 1'b0; q_Run = 1'b1;
        bus.SCEN = 1'b0; bus.In_Dirn = U;
        repeat (3) tick_clk();
        check_outputs("reset", 1'b0, R, '0, 1'b0);
        Reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick_clk();
            check($sformatf("hold_high%0d Step", i), 8'(bus.Step), 8'd0);
        end
        Speed_Clk = 1'b0;
        repeat (4) tick_clk();

        // First Step appears on the third edge after Speed_Clk is sampled high.
        Speed_Clk = 1'b1;
        edges = 0;
        for (int i = 1; i <= 10; i++) begin
            tick_clk();
            if (bus.Step) begin
                edges = i;
                break;
            end
        end
        check("step_latency", 8'(edges), 8'd3);
        for (int i = 0; i < 3; i++) begin
            tick_clk();
            check($sformatf("single_step%0d Step", i), 8'(bus.Step), 8'd0);
        end

        //  rst scen dirn spd qi qrun | step dirn cnt drop
        // Reversal drop, accept, tick pop, duplicate drop.
        v(0,1,L,0,0,1, 0,R,0,1);
        v(0,1,U,0,0,1, 0,R,1,0);
        v(0,0,U,0,0,1, 0,R,1,0);
        v(0,0,U,1,0,1, 0,R,1,0);
        v(0,0,U,1,0,1, 0,R,1,0);
        v(0,0,U,1,0,1, 1,U,0,0);
        v(0,0,U,1,0,1, 0,U,0,0);
        v(0,1,U,0,0,1, 0,U,0,1);
        v(0,1,L,0,0,1, 0,U,1,0);
        v(0,0,U,0,0,1, 0,U,1,0);
        v(0,0,U,1,0,1, 0,U,1,0);
        v(0,0,U,1,0,1, 0,U,1,0);
        v(0,0,U,1,0,1, 1,L,0,0);
        // Fill to DEPTH, fifth command dropped as full.
        v(0,1,U,0,0,1, 0,L,1,0);
        v(0,1,L,0,0,1, 0,L,2,0);
        v(0,1,D,0,0,1, 0,L,3,0);
        v(0,1,R,0,0,1, 0,L,4,0);
        v(0,1,U,0,0,1, 0,L,4,1);
        // Four ticks drain in order.
        for (int k = 0; k < 4; k++) begin
            logic [1:0] exp_d;
            exp_d = (k == 0) ? U : (k == 1) ? L : (k == 2) ? D : R;
            v(0,0,U,1,0,1, 0,(k == 0) ? L : vecs[vecs.size()-1].e_dirn, CW'(4-k),0);
            v(0,0,U,1,0,1, 0,vecs[vecs.size()-1].e_dirn, CW'(4-k),0);
            v(0,0,U,0,0,1, 1,exp_d, CW'(3-k),0);
            v(0,0,U,0,0,1, 0,exp_d, CW'(3-k),0);
        end
        // Push accepted on the same edge a pop frees a slot of a full queue.
        v(0,1,U,0,0,1, 0,R,1,0);
        v(0,1,L,0,0,1, 0,R,2,0);
        v(0,1,D,0,0,1, 0,R,3,0);
        v(0,1,R,0,0,1, 0,R,4,0);
        v(0,0,U,1,0,1, 0,R,4,0);
        v(0,0,U,1,0,1, 0,R,4,0);
        v(0,1,U,0,0,1, 1,U,4,0);
        v(0,1,D,0,0,1, 0,U,4,1);
        v(0,0,U,1,0,1, 0,U,4,0);
        v(0,0,U,1,0,1, 0,U,4,0);
        v(0,0,U,0,0,1, 1,L,3,0);
        v(0,0,U,0,0,1, 0,L,3,0);
        v(0,0,U,1,0,1, 0,L,3,0);
        v(0,0,U,1,0,1, 0,L,3,0);
        v(0,0,U,0,0,1, 1,D,2,0);
        v(0,0,U,0,0,1, 0,D,2,0);
        // Initial state flushes and ignores SCEN.
        v(0,0,U,0,1,0, 0,R,0,0);
        v(0,1,L,0,1,0, 0,R,0,0);
        v(0,1,D,0,0,1, 0,R,1,0);
        v(0,1,L,0,0,1, 0,R,2,0);
        // Lose: frozen, no Step, no Drop.
        v(0,1,U,1,0,0, 0,R,2,0);
        v(0,0,U,1,0,0, 0,R,2,0);
        v(0,0,U,0,0,0, 0,R,2,0);
        v(0,0,U,0,0,0, 0,R,2,0);
        v(0,0,U,1,0,0, 0,R,2,0);
        v(0,0,U,1,0,0, 0,R,2,0);
        v(0,0,U,0,0,0, 0,R,2,0);
        v(0,0,U,0,0,0, 0,R,2,0);
        // Back to Run: no burst, then one real tick, then reset overrides a duplicate.
        v(0,0,U,1,0,1, 0,R,2,0);
        v(0,0,U,1,0,1, 0,R,2,0);
        v(0,0,U,0,0,1, 1,D,1,0);
        v(1,1,L,1,0,1, 0,R,0,0);
        v(0,0,U,1,0,1, 0,R,0,0);
        v(0,0,U,1,0,1, 0,R,0,0);
        v(0,0,U,1,0,1, 0,R,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            Reset       = vecs[i].rst;
            bus.SCEN    = vecs[i].scen;
            bus.In_Dirn = vecs[i].dirn;
            Speed_Clk   = vecs[i].spd;
            q_I         = vecs[i].qi;
            q_Run       = vecs[i].qrun;
            tick_clk();
            check_outputs($sformatf("vec%0d", i), vecs[i].e_step, vecs[i].e_dirn,
                          vecs[i].e_cnt, vecs[i].e_drop);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
